count_snapshot_fifo: RTL and testbench

//   Downstream consumer of the free-running 64-bit counter output y.
//   On each event strobe, captures the current count value as a timestamp.

---
 rtl/count_snapshot_fifo.sv | 93 +++++++++
 tb/tb_count_snapshot_fifo.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/count_snapshot_fifo.sv
// Timestamp capture FIFO: snapshots a live counter on each event strobe and
// streams the captured values out over a valid/ready interface.
module count_snapshot_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int DROPW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     event_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [DROPW-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push;
    logic             pop;
    logic             drop;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr];

    assign pop  = out_valid & out_ready;
    assign push = event_in & (~full | pop);
    assign drop = event_in & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= count_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // Drop counter saturates so a long overrun never wraps to small values
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

`ifdef FORMAL
    logic past_ok = 1'b0;
    always_ff @(posedge clk) past_ok <= 1'b1;

    always_ff @(posedge clk) begin
        assert (level <= LW'(DEPTH));
        assert (!(full && empty));
        if (past_ok && !$past(rst)) begin
            if ($past(out_valid && !out_ready)) begin
                assert (out_data == $past(out_data));
            end
            if ($past(overflow)) begin
                assert (overflow);
            end
            assert (drop_cnt >= $past(drop_cnt));
        end
    end
`endif

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Directed bench for count_snapshot_fifo with hand-computed expected values.
module tb_count_snapshot_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] count_in;
    logic        event_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [2:0]  level;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int vectors = 0;
    int errors  = 0;

    count_snapshot_fifo #(.WIDTH(64), .DEPTH(4), .DROPW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .event_in  (event_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; event_in = 1'b0; out_ready = 1'b0; count_in = '0;
        // 1: reset held two cycles
        tick(); tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        rst = 1'b0;

        // 2: single capture, one cycle latency
        count_in = 64'd100; event_in = 1'b1;
        tick();
        event_in = 1'b0; count_in = 64'd555;
        chk("one_valid", 64'(out_valid), 64'd1);
        chk("one_data", out_data, 64'd100);
        chk("one_level", 64'(level), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("one_drained", 64'(empty), 64'd1);

        // 3: fill, overflow, drain in order
        for (int i = 0; i < 4; i++) begin
            count_in = 64'(10 + i); event_in = 1'b1;
            tick();
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_level", 64'(level), 64'd4);
        chk("fill_ovf0", 64'(overflow), 64'd0);
        count_in = 64'd14;
        tick();
        event_in = 1'b0;
        chk("drop_ovf", 64'(overflow), 64'd1);
        chk("drop_cnt", 64'(drop_cnt), 64'd1);
        chk("drop_full", 64'(full), 64'd1);
        chk("drop_head", out_data, 64'd10);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain", out_data, 64'(10 + i));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_ovf_sticky", 64'(overflow), 64'd1);

        // 4: full with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            count_in = 64'(20 + i); event_in = 1'b1;
            tick();
        end
        count_in = 64'd24; out_ready = 1'b1;
        tick();
        event_in = 1'b0;
        chk("pp_level", 64'(level), 64'd4);
        chk("pp_nodrop", 64'(drop_cnt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("pp_drain", out_data, 64'(21 + i));
            tick();
        end
        chk("pp_empty", 64'(empty), 64'd1);

        // 5: streaming, fresh reset
        rst = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            count_in = 64'(1000 + i); event_in = 1'b1;
            tick();
            chk("stream_data", out_data, 64'(1000 + i));
            chk("stream_level", 64'(level), 64'd1);
        end
        event_in = 1'b0;
        chk("stream_drop", 64'(drop_cnt), 64'd0);
        tick();
        chk("stream_empty", 64'(empty), 64'd1);

        // 6: saturate drop counter, then reset mid-flight
        out_ready = 1'b0; event_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            count_in = 64'(40 + i);
            tick();
        end
        for (int i = 0; i < 260; i++) begin
            count_in = 64'(500 + i);
            tick();
        end
        event_in = 1'b0;
        chk("sat_drop", 64'(drop_cnt), 64'd255);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("sat_level3", 64'(level), 64'd3);
        chk("sat_head", out_data, 64'd41);
        rst = 1'b1; event_in = 1'b1; out_ready = 1'b1; count_in = 64'd9;
        tick();
        rst = 1'b0; event_in = 1'b0; out_ready = 1'b0;
        chk("clr_level", 64'(level), 64'd0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_drop", 64'(drop_cnt), 64'd0);
        chk("clr_data", out_data, 64'd0);
        chk("clr_valid", 64'(out_valid), 64'd0);
        count_in = 64'd77; event_in = 1'b1;
        tick();
        event_in = 1'b0;
        chk("post_data", out_data, 64'd77);
        chk("post_level", 64'(level), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
